// File: rtl/vx_fpu_csr_unit_pkg.sv
//============================================================================
// Module : VX_fpu_pkg
// Brief  : FPU CSR types, request-op encoding and shared CSR defines.
// Rev    : 1.0
//============================================================================
`default_nettype none

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_FPU_BLOCKS
`define NUM_FPU_BLOCKS 2
`endif
`ifndef FPUQ_SIZE
`define FPUQ_SIZE 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef INST_FRM_BITS
`define INST_FRM_BITS 3
`endif
`ifndef VX_CSR_FFLAGS
`define VX_CSR_FFLAGS 12'h001
`endif
`ifndef VX_CSR_FRM
`define VX_CSR_FRM 12'h002
`endif
`ifndef VX_CSR_FCSR
`define VX_CSR_FCSR 12'h003
`endif

package VX_fpu_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'd0,
    CSR_OP_SET   = 2'd1,
    CSR_OP_CLEAR = 2'd2,
    CSR_OP_READ  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } csr_state_e;

  function automatic logic [7:0] csr_apply(input csr_op_e op,
                                           input logic [7:0] old_val,
                                           input logic [7:0] opnd);
    case (op)
      CSR_OP_WRITE: csr_apply = opnd;
      CSR_OP_SET:   csr_apply = old_val | opnd;
      CSR_OP_CLEAR: csr_apply = old_val & ~opnd;
      default:      csr_apply = old_val;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_fpu_csr_unit_pending.sv
//============================================================================
// Module : VX_fpu_csr_pending
// Brief  : Per-warp count of FPU ops issued but not yet retired.
//          Built only when FPU_CSR_DRAIN_EN is defined.
// Rev    : 1.0
//============================================================================
`default_nettype none

`ifdef FPU_CSR_DRAIN_EN
module VX_fpu_csr_pending #(
  parameter NUM_WARPS    = `NUM_WARPS,
  parameter NUM_BLOCKS   = `NUM_FPU_BLOCKS,
  parameter PENDING_SIZE = `FPUQ_SIZE,
  parameter CNT_W        = $clog2(NUM_BLOCKS * PENDING_SIZE + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_BLOCKS-1:0]                 i_issue_valid,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]  i_issue_wid,
  input  logic [NUM_BLOCKS-1:0]                 i_commit_valid,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]  i_commit_wid,
  output logic [NUM_WARPS-1:0][CNT_W-1:0]       o_pending
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(NUM_BLOCKS * PENDING_SIZE);

  for (genvar W = 0; W < NUM_WARPS; W++) begin : g_warp
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_inc;
    logic [CNT_W:0]   w_dec;
    logic [CNT_W:0]   w_sum;

    always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        if (i_issue_valid[b] && i_issue_wid[b] == `NW_WIDTH'(W))
          w_inc = w_inc + (CNT_W + 1)'(1);
        if (i_commit_valid[b] && i_commit_wid[b] == `NW_WIDTH'(W))
          w_dec = w_dec + (CNT_W + 1)'(1);
      end
      w_sum = {1'b0, r_cnt} + w_inc;
    end

    // Retiring more than is outstanding is a pipeline bug; clamp at zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else begin
        assert (w_sum >= w_dec);
        assert ((w_sum < w_dec) || ((w_sum - w_dec) <= MAX_CNT));
        if (w_sum < w_dec)
          r_cnt <= '0;
        else
          r_cnt <= CNT_W'(w_sum - w_dec);
      end
    end

    assign o_pending[W] = r_cnt;
  end

endmodule
`endif

`default_nettype wire

// File: rtl/vx_fpu_csr_unit.sv
//============================================================================
// Module : vx_fpu_csr_unit
// Brief  : Per-warp fflags/frm storage with CSR access; FPU_CSR_DRAIN_EN
//          adds in-flight tracking so flag reads wait for the FPU to drain.
// Rev    : 1.0
//============================================================================
`default_nettype none

module vx_fpu_csr_unit
  import VX_fpu_pkg::*;
#(
  parameter NUM_WARPS    = `NUM_WARPS,
  parameter NUM_BLOCKS   = `NUM_FPU_BLOCKS,
  parameter PENDING_SIZE = `FPUQ_SIZE
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]      fpu_read_wid,
  output logic [NUM_BLOCKS-1:0][`INST_FRM_BITS-1:0] fpu_read_frm,
  input  logic [NUM_BLOCKS-1:0]                     fpu_write_enable,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]      fpu_write_wid,
  input  logic [NUM_BLOCKS-1:0][4:0]                fpu_write_fflags,
  input  logic [NUM_BLOCKS-1:0]                     fpu_issue_valid,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]      fpu_issue_wid,
  input  logic [NUM_BLOCKS-1:0]                     fpu_commit_valid,
  input  logic [NUM_BLOCKS-1:0][`NW_WIDTH-1:0]      fpu_commit_wid,
  input  logic                                      csr_req_valid,
  output logic                                      csr_req_ready,
  input  logic [`NW_WIDTH-1:0]                      csr_req_wid,
  input  logic [11:0]                               csr_req_addr,
  input  logic [1:0]                                csr_req_op,
  input  logic [7:0]                                csr_req_wdata,
  output logic                                      csr_rsp_valid,
  output logic [31:0]                               csr_rsp_data
);

  fflags_t                    r_fflags [NUM_WARPS];
  logic [`INST_FRM_BITS-1:0]  r_frm    [NUM_WARPS];
  logic                       r_rsp_valid;
  logic [31:0]                r_rsp_data;

  logic [4:0] w_fpu_flags [NUM_WARPS];
  logic       w_is_fflags;
  logic       w_is_frm;
  logic       w_is_fcsr;
  logic [7:0] w_old;
  logic [7:0] w_opnd;
  logic [7:0] w_new;
  logic       w_ready;
  logic       w_accept;

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_read
    assign fpu_read_frm[b] = r_frm[fpu_read_wid[b]];
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_fpu_flags[w] = '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        if (fpu_write_enable[b] && fpu_write_wid[b] == `NW_WIDTH'(w))
          w_fpu_flags[w] = w_fpu_flags[w] | fpu_write_fflags[b];
      end
    end
  end

  assign w_is_fflags = (csr_req_addr == `VX_CSR_FFLAGS);
  assign w_is_frm    = (csr_req_addr == `VX_CSR_FRM);
  assign w_is_fcsr   = (csr_req_addr == `VX_CSR_FCSR);

  // Operate in the field's own bit space; unknown addresses see zero.
  always_comb begin
    w_old  = '0;
    w_opnd = '0;
    if (w_is_fflags) begin
      w_old  = {3'b000, r_fflags[csr_req_wid]};
      w_opnd = {3'b000, csr_req_wdata[4:0]};
    end else if (w_is_frm) begin
      w_old  = {5'b00000, r_frm[csr_req_wid]};
      w_opnd = {5'b00000, csr_req_wdata[2:0]};
    end else if (w_is_fcsr) begin
      w_old  = {r_frm[csr_req_wid], r_fflags[csr_req_wid]};
      w_opnd = csr_req_wdata;
    end
    w_new = csr_apply(csr_op_e'(csr_req_op), w_old, w_opnd);
  end

  assign w_accept = csr_req_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_fflags[w] <= '0;
        r_frm[w]    <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        // FPU flags landing with a CSR write still accumulate on top of it.
        if (w_accept && csr_req_wid == `NW_WIDTH'(w) && (w_is_fflags || w_is_fcsr))
          r_fflags[w] <= w_new[4:0] | w_fpu_flags[w];
        else
          r_fflags[w] <= r_fflags[w] | w_fpu_flags[w];
        if (w_accept && csr_req_wid == `NW_WIDTH'(w) && w_is_frm)
          r_frm[w] <= w_new[2:0];
        else if (w_accept && csr_req_wid == `NW_WIDTH'(w) && w_is_fcsr)
          r_frm[w] <= w_new[7:5];
      end
      r_rsp_valid <= w_accept;
      if (w_accept)
        r_rsp_data <= {24'b0, w_old};
    end
  end

`ifdef FPU_CSR_DRAIN_EN
  localparam int CNT_W = $clog2(NUM_BLOCKS * PENDING_SIZE + 1);

  logic [NUM_WARPS-1:0][CNT_W-1:0] w_pending;
  csr_state_e                      r_state;
  logic                            w_pend_zero;
  logic                            w_issue_hit;

  VX_fpu_csr_pending #(
    .NUM_WARPS    (NUM_WARPS),
    .NUM_BLOCKS   (NUM_BLOCKS),
    .PENDING_SIZE (PENDING_SIZE),
    .CNT_W        (CNT_W)
  ) u_pending (
    .clk            (clk),
    .reset          (reset),
    .i_issue_valid  (fpu_issue_valid),
    .i_issue_wid    (fpu_issue_wid),
    .i_commit_valid (fpu_commit_valid),
    .i_commit_wid   (fpu_commit_wid),
    .o_pending      (w_pending)
  );

  assign w_pend_zero = (w_pending[csr_req_wid] == '0);

  always_comb begin
    w_issue_hit = 1'b0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (fpu_issue_valid[b] && fpu_issue_wid[b] == csr_req_wid)
        w_issue_hit = 1'b1;
    end
  end

  // frm is never written by the FPU, so only flag accesses must wait.
  always_comb begin
    w_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE:    w_ready = csr_req_valid && (w_is_frm || (w_pend_zero && !w_issue_hit));
        SETTLE:  w_ready = 1'b1;
        default: w_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (csr_req_valid && (w_is_fflags || w_is_fcsr) && !w_pend_zero)
                   r_state <= DRAIN;
        DRAIN:   if (w_pend_zero)
                   r_state <= SETTLE;
        SETTLE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused_fpu_pipe;
  assign w_unused_fpu_pipe = ^{fpu_issue_valid, fpu_issue_wid, fpu_commit_valid,
                               fpu_commit_wid, (PENDING_SIZE > 0)};
  assign w_ready = !reset;
`endif

  assign csr_req_ready = w_ready;
  assign csr_rsp_valid = r_rsp_valid;
  assign csr_rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_vx_fpu_csr_unit.sv
//============================================================================
// Module : tb_vx_fpu_csr_unit
// Brief  : Self-checking bench for vx_fpu_csr_unit against a per-warp model.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_vx_fpu_csr_unit;

  localparam int NW = 4;
  localparam int NB = 2;
  localparam int PQ = 4;
`ifdef FPU_CSR_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif
  localparam logic [11:0] A_FFLAGS = 12'h001;
  localparam logic [11:0] A_FRM    = 12'h002;
  localparam logic [11:0] A_FCSR   = 12'h003;
  localparam logic [11:0] A_OTHER  = 12'h300;

  logic                clk;
  logic                reset;
  logic [NB-1:0][1:0]  fpu_read_wid;
  logic [NB-1:0][2:0]  fpu_read_frm;
  logic [NB-1:0]       fpu_write_enable;
  logic [NB-1:0][1:0]  fpu_write_wid;
  logic [NB-1:0][4:0]  fpu_write_fflags;
  logic [NB-1:0]       fpu_issue_valid;
  logic [NB-1:0][1:0]  fpu_issue_wid;
  logic [NB-1:0]       fpu_commit_valid;
  logic [NB-1:0][1:0]  fpu_commit_wid;
  logic                csr_req_valid;
  logic                csr_req_ready;
  logic [1:0]          csr_req_wid;
  logic [11:0]         csr_req_addr;
  logic [1:0]          csr_req_op;
  logic [7:0]          csr_req_wdata;
  logic                csr_rsp_valid;
  logic [31:0]         csr_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] m_fflags [NW];
  logic [2:0] m_frm    [NW];

  vx_fpu_csr_unit #(
    .NUM_WARPS    (NW),
    .NUM_BLOCKS   (NB),
    .PENDING_SIZE (PQ)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fpu_read_wid     (fpu_read_wid),
    .fpu_read_frm     (fpu_read_frm),
    .fpu_write_enable (fpu_write_enable),
    .fpu_write_wid    (fpu_write_wid),
    .fpu_write_fflags (fpu_write_fflags),
    .fpu_issue_valid  (fpu_issue_valid),
    .fpu_issue_wid    (fpu_issue_wid),
    .fpu_commit_valid (fpu_commit_valid),
    .fpu_commit_wid   (fpu_commit_wid),
    .csr_req_valid    (csr_req_valid),
    .csr_req_ready    (csr_req_ready),
    .csr_req_wid      (csr_req_wid),
    .csr_req_addr     (csr_req_addr),
    .csr_req_op       (csr_req_op),
    .csr_req_wdata    (csr_req_wdata),
    .csr_rsp_valid    (csr_rsp_valid),
    .csr_rsp_data     (csr_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] old_v,
                                          input logic [7:0] v);
    case (op)
      2'd0:    model_op = v;
      2'd1:    model_op = old_v | v;
      2'd2:    model_op = old_v & ~v;
      default: model_op = old_v;
    endcase
  endfunction

  task automatic idle_inputs();
    fpu_read_wid     = '0;
    fpu_write_enable = '0;
    fpu_write_wid    = '0;
    fpu_write_fflags = '0;
    fpu_issue_valid  = '0;
    fpu_issue_wid    = '0;
    fpu_commit_valid = '0;
    fpu_commit_wid   = '0;
    csr_req_valid    = 1'b0;
    csr_req_wid      = '0;
    csr_req_addr     = '0;
    csr_req_op       = '0;
    csr_req_wdata    = '0;
  endtask

  task automatic csr_req(input logic [1:0] wid, input logic [11:0] addr,
                         input logic [1:0] op, input logic [7:0] wdata);
    csr_req_valid = 1'b1;
    csr_req_wid   = wid;
    csr_req_addr  = addr;
    csr_req_op    = op;
    csr_req_wdata = wdata;
  endtask

  // One clock: check combinational outputs, advance the model, check response.
  task automatic cycle(input bit exp_ready);
    logic [7:0] old_v, opnd, new_v;
    logic [4:0] nf [NW];
    logic [2:0] nr [NW];
    bit         acc;
    #1;
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        n_checks++;
        if (fpu_read_frm[b] !== m_frm[fpu_read_wid[b]]) begin
          n_fail++;
          $display("FAIL read_frm[%0d]: got %0d expected %0d", b, fpu_read_frm[b],
                   m_frm[fpu_read_wid[b]]);
        end
      end
    end
    if (csr_req_valid) begin
      n_checks++;
      if (csr_req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL csr_req_ready: got %b expected %b", csr_req_ready, exp_ready);
      end
    end
    acc   = csr_req_valid && exp_ready && !reset;
    old_v = '0;
    opnd  = '0;
    case (csr_req_addr)
      A_FFLAGS: begin old_v = {3'b0, m_fflags[csr_req_wid]}; opnd = {3'b0, csr_req_wdata[4:0]}; end
      A_FRM:    begin old_v = {5'b0, m_frm[csr_req_wid]};    opnd = {5'b0, csr_req_wdata[2:0]}; end
      A_FCSR:   begin old_v = {m_frm[csr_req_wid], m_fflags[csr_req_wid]}; opnd = csr_req_wdata; end
      default:  ;
    endcase
    new_v = model_op(csr_req_op, old_v, opnd);
    for (int w = 0; w < NW; w++) begin
      nf[w] = m_fflags[w];
      nr[w] = m_frm[w];
    end
    if (acc) begin
      if (csr_req_addr == A_FFLAGS || csr_req_addr == A_FCSR) nf[csr_req_wid] = new_v[4:0];
      if (csr_req_addr == A_FRM) nr[csr_req_wid] = new_v[2:0];
      if (csr_req_addr == A_FCSR) nr[csr_req_wid] = new_v[7:5];
    end
    for (int b = 0; b < NB; b++)
      if (fpu_write_enable[b]) nf[fpu_write_wid[b]] = nf[fpu_write_wid[b]] | fpu_write_fflags[b];
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        nf[w] = '0;
        nr[w] = '0;
      end
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < NW; w++) begin
      m_fflags[w] = nf[w];
      m_frm[w]    = nr[w];
    end
    n_checks++;
    if (csr_rsp_valid !== acc) begin
      n_fail++;
      $display("FAIL csr_rsp_valid: got %b expected %b", csr_rsp_valid, acc);
    end
    if (acc) begin
      n_checks++;
      if (csr_rsp_data !== {24'b0, old_v}) begin
        n_fail++;
        $display("FAIL csr_rsp_data: got %h expected %h", csr_rsp_data, {24'b0, old_v});
      end
    end
    @(negedge clk);
  endtask

  task automatic check_rsp(input string name, input logic [31:0] exp);
    n_checks++;
    if (csr_rsp_valid !== 1'b1 || csr_rsp_data !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", name,
               csr_rsp_valid, csr_rsp_data, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    csr_req(2'd0, A_FCSR, 2'd3, 8'h00);
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
    idle_inputs();
    for (int w = 0; w < NW; w++) begin
      fpu_read_wid[0] = 2'(w);
      fpu_read_wid[1] = 2'(NW - 1 - w);
      csr_req(2'(w), A_FCSR, 2'd3, 8'hFF);
      cycle(1'b1);
    end
    idle_inputs();
    cycle(1'b1);
  endtask

  task automatic test_fcsr_read();
    csr_req(2'd2, A_FCSR, 2'd3, 8'h5A);
    cycle(1'b1);
    check_rsp("fcsr_read_after_reset", 32'h0);
    idle_inputs();
    cycle(1'b1);
  endtask

  task automatic test_frm_write();
    csr_req(2'd1, A_FRM, 2'd0, 8'h03);
    cycle(1'b1);
    idle_inputs();
    fpu_read_wid[0] = 2'd1;
    #1;
    n_checks++;
    if (fpu_read_frm[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL frm_lookup: got %0d expected 3", fpu_read_frm[0]);
    end
    cycle(1'b1);
  endtask

  task automatic test_fflags_merge();
    idle_inputs();
    fpu_write_enable    = 2'b11;
    fpu_write_wid[0]    = 2'd0;
    fpu_write_wid[1]    = 2'd0;
    fpu_write_fflags[0] = 5'h01;
    fpu_write_fflags[1] = 5'h10;
    cycle(1'b1);
    idle_inputs();
    csr_req(2'd0, A_FFLAGS, 2'd3, 8'h00);
    cycle(1'b1);
    check_rsp("fflags_merge", 32'h11);
    idle_inputs();
  endtask

  task automatic test_clear_race();
    csr_req(2'd0, A_FFLAGS, 2'd2, 8'h1F);
    fpu_write_enable    = 2'b01;
    fpu_write_wid[0]    = 2'd0;
    fpu_write_fflags[0] = 5'h02;
    cycle(1'b1);
    idle_inputs();
    csr_req(2'd0, A_FFLAGS, 2'd3, 8'h00);
    cycle(1'b1);
    check_rsp("clear_vs_fpu_write", 32'h02);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    csr_req(2'd2, A_FCSR, 2'd0, 8'hA5);
    cycle(1'b1);
    csr_req(2'd2, A_FFLAGS, 2'd1, 8'h0A);
    cycle(1'b1);
    csr_req(2'd2, A_FRM, 2'd2, 8'hF9);
    cycle(1'b1);
    csr_req(2'd2, A_FCSR, 2'd3, 8'h00);
    cycle(1'b1);
    check_rsp("b2b_fcsr", 32'h8F);
    csr_req(2'd2, A_OTHER, 2'd0, 8'hFF);
    cycle(1'b1);
    check_rsp("unknown_addr", 32'h0);
    csr_req(2'd2, A_FCSR, 2'd3, 8'h00);
    cycle(1'b1);
    check_rsp("unknown_no_write", 32'h8F);
    idle_inputs();
    cycle(1'b1);
  endtask

  task automatic test_random();
    logic [11:0] addrs [4];
    addrs[0] = A_FFLAGS;
    addrs[1] = A_FRM;
    addrs[2] = A_FCSR;
    addrs[3] = A_OTHER;
    for (int i = 0; i < 300; i++) begin
      fpu_write_enable = 2'($urandom_range(0, 3));
      for (int b = 0; b < NB; b++) begin
        fpu_write_wid[b]    = 2'($urandom_range(0, NW - 1));
        fpu_write_fflags[b] = 5'($urandom_range(0, 31));
        fpu_read_wid[b]     = 2'($urandom_range(0, NW - 1));
      end
      csr_req_valid = 1'($urandom_range(0, 1));
      csr_req_wid   = 2'($urandom_range(0, NW - 1));
      csr_req_addr  = addrs[$urandom_range(0, 3)];
      csr_req_op    = 2'($urandom_range(0, 3));
      csr_req_wdata = 8'($urandom_range(0, 255));
      cycle(1'b1);
    end
    idle_inputs();
    cycle(1'b1);
  endtask

  task automatic test_drain();
    idle_inputs();
    fpu_issue_valid  = 2'b01;
    fpu_issue_wid[0] = 2'd3;
    cycle(1'b1);
    cycle(1'b1);
    idle_inputs();
    csr_req(2'd3, A_FFLAGS, 2'd3, 8'h00);
    cycle(!DRAIN_EN);
    fpu_commit_valid  = 2'b01;
    fpu_commit_wid[0] = 2'd3;
    cycle(!DRAIN_EN);
    fpu_commit_valid    = 2'b10;
    fpu_commit_wid[1]   = 2'd3;
    fpu_write_enable    = 2'b10;
    fpu_write_wid[1]    = 2'd3;
    fpu_write_fflags[1] = 5'h04;
    cycle(!DRAIN_EN);
    fpu_commit_valid = '0;
    fpu_write_enable = '0;
    cycle(!DRAIN_EN);
    cycle(1'b1);
    check_rsp("drain_read", 32'h04);
    idle_inputs();
    cycle(1'b1);
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    fpu_issue_valid  = 2'b01;
    fpu_issue_wid[0] = 2'd2;
    csr_req(2'd2, A_FCSR, 2'd3, 8'h00);
    cycle(!DRAIN_EN);
    fpu_issue_valid = '0;
    cycle(!DRAIN_EN);
    cycle(!DRAIN_EN);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    cycle(1'b1);
    check_rsp("post_reset_accept", 32'h0);
    idle_inputs();
    cycle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fcsr_read();
    test_frm_write();
    test_fflags_merge();
    test_clear_race();
    test_back_to_back();
    test_random();
    test_reset();
    test_drain();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
